stopwatch_time_counter: RTL and testbench
=========================================

# stopwatch_time_counter

Time-base and BCD digit counter for the stopwatch, directly downstream of the stopwatch control FSM. The FSM drives `clear`, `run` and `fast` from its CLEAR, RUN-1x, RUN-10x and PAUSE states. This block divides the system clock into hundredth-of-a-second ticks (or ten times faster in fast mode) and keeps an MM:SS.hh count in six BCD digits. Its outputs feed the display/seven-segment driver.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000, system clock frequency.
  - Must be a multiple of 1000 and ≥ 1000.
  - `DIV = CLK_HZ/100` is the normal tick period in cycles.
  - `DIV_FAST = CLK_HZ/1000` is the fast tick period in cycles.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clear`  in  1  synchronous counter clear, driven while the FSM is in CLEAR.
- `run`  in  1  1 = count, 0 = hold (PAUSE).
- `fast`  in  1  1 = 10x tick rate, 0 = normal rate.
- `lap`  in  1  single-cycle lap/split pulse.
- `min_t`, `min_o`  out  4  minutes tens (0-5) and ones (0-9), BCD, display view.
- `sec_t`, `sec_o`  out  4  seconds tens (0-5) and ones (0-9), BCD, display view.
- `hun_t`, `hun_o`  out  4  hundredths tens and ones (0-9), BCD, display view.
- `tick`  out  1  one-cycle pulse on every count increment.
- `wrap`  out  1  one-cycle pulse when the count wraps from 59:59.99 to 00:00.00.
- `lap_active`  out  1  display view is frozen on a lap capture.

## Operation
- **Prescaler**
  - Width is `$clog2(DIV)`.
  - The active limit `L` is `DIV_FAST` when `fast`=1, otherwise `DIV`.
  - When `run`=1: if prescaler ≥ `L-1`, the prescaler goes to 0 and an increment occurs; otherwise the prescaler increments by 1.
  - The `≥` compare covers a `fast` change while the prescaler is above the new limit: the increment fires on that cycle.
  - When `run`=0: prescaler and digits hold. A partial tick period is preserved across pause/resume.
- **Increment cascade (live count)**
  - `hun_o` counts 9→0 with carry into `hun_t`; `hun_t` 9→0 with carry into `sec_o`.
  - `sec_o` 9→0 with carry into `sec_t`; `sec_t` 5→0 with carry into `min_o`.
  - `min_o` 9→0 with carry into `min_t`; `min_t` 5→0 with carry out.
  - A carry out of `min_t` produces `wrap`, and the count reads 00:00.00.
  - Digits never hold values outside their ranges.
- **Priority:** `rst` > `clear` > increment.
  - `clear` zeroes all live digits and the prescaler, suppresses `tick`/`wrap` that cycle, and releases any lap hold.
  - `clear` while `run`=1 still clears; counting resumes from 0 on the following cycle if `run` stays high.
- **Display view**
  - Outputs equal the live count unless a lap hold is active (see Configuration).
- **Reset values**
  - All digit outputs 0; prescaler 0.
  - `tick`, `wrap` and `lap_active` 0.

## Timing
- All outputs are registered.
- Digit update, `tick` and `wrap` are asserted on the same clock edge.
- From reset or clear release, with `run`=1 held, the first `tick` is high in cycle `L` after release, then every `L` cycles.
- `tick` and `wrap` are exactly one cycle wide. `wrap` implies `tick`.
- `lap` is sampled each cycle. A capture takes effect on the edge that samples `lap`=1, and the display is frozen from the next cycle.
- `lap` coincident with `clear`: `clear` wins, no hold.
- `lap` coincident with an increment: the pre-increment value is captured.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined:** `lap` toggles the hold.
  - Pulse while not holding: the live digits are copied into the display registers and `lap_active`=1. Counting continues underneath.
  - Pulse while holding: the display returns to live and `lap_active`=0.
  - `clear` or `rst` forces `lap_active`=0.
- **Undefined:** `lap` is ignored, `lap_active` is tied to 0, the display is always live, and no hold registers are instantiated.

## Test plan
All scenarios use `CLK_HZ`=1000, so `DIV`=10 and `DIV_FAST`=1.
- **Normal rate:** `rst` then `run`=1, `fast`=0 for 100 cycles → exactly 10 `tick` pulses, at cycles 10, 20, … 100; display reads 00:00.10.
- **Fast rate and pause:** `run`=1 with `fast`=1 for 25 cycles → 00:00.25. Then `run`=0 for 50 cycles → no change. Then `fast`=0, `run`=1 for 10 cycles → 00:00.26.
- **Wrap:** preload to 59:59.99 by running `fast` for 359,999 cycles, then 1 more tick → 00:00.00 and `wrap`=1 for exactly that one cycle.
- **Clear mid-period:** run 7 cycles (prescaler=7), then assert `clear` for 1 cycle with `run`=1 → digits 0 and no `tick`; the next `tick` is 10 cycles after `clear` deasserts.
- **Lap (with `STOPWATCH_LAP_EN`):** at 00:00.30, pulse `lap` → display holds 00:00.30 and `lap_active`=1 while the live count advances 20 more ticks. A second `lap` pulse → display shows 00:00.50 and `lap_active`=0. Without the macro, the same stimulus → display is always live.
- **Reset mid-run:** assert `rst` at 00:12.34 with `lap_active`=1 → next cycle all outputs 0 and `lap_active`=0.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base and MM:SS.hh BCD counter with tick/wrap pulses.
// Optional lap hold of the displayed value is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_time_counter #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    input  logic       fast,
    input  logic       lap,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] hun_t,
    output logic [3:0] hun_o,
    output logic       tick,
    output logic       wrap,
    output logic       lap_active
);

    localparam int DIV      = CLK_HZ / 100;
    localparam int DIV_FAST = CLK_HZ / 1000;
    localparam int PW       = $clog2(DIV);
    localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 1);
    localparam logic [PW-1:0] FAST_M1 = PW'(DIV_FAST - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] limit_m1;
    logic          inc;

    logic [3:0] l_mt, l_mo, l_st, l_so, l_ht, l_ho;
    logic [3:0] n_mt, n_mo, n_st, n_so, n_ht, n_ho;
    logic       c1, c2, c3, c4, c5, c6;

    // One BCD digit step: roll to 0 past its maximum when a carry arrives.
    function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] max, input logic cin);
        if (!cin)
            return d;
        else if (d >= max)
            return 4'd0;
        else
            return d + 4'd1;
    endfunction

    // ">=" rather than "==" so a switch to fast mode above the new limit fires at once.
    always_comb begin
        limit_m1 = fast ? FAST_M1 : DIV_M1;
        inc      = run && (pre >= limit_m1);
        c1 = inc && (l_ho == 4'd9);
        c2 = c1  && (l_ht == 4'd9);
        c3 = c2  && (l_so == 4'd9);
        c4 = c3  && (l_st == 4'd5);
        c5 = c4  && (l_mo == 4'd9);
        c6 = c5  && (l_mt == 4'd5);
        n_ho = bump(l_ho, 4'd9, inc);
        n_ht = bump(l_ht, 4'd9, c1);
        n_so = bump(l_so, 4'd9, c2);
        n_st = bump(l_st, 4'd5, c3);
        n_mo = bump(l_mo, 4'd9, c4);
        n_mt = bump(l_mt, 4'd5, c5);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre  <= '0;
            l_mt <= 4'd0;
            l_mo <= 4'd0;
            l_st <= 4'd0;
            l_so <= 4'd0;
            l_ht <= 4'd0;
            l_ho <= 4'd0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            if (run)
                pre <= inc ? '0 : pre + 1'b1;
            l_mt <= n_mt;
            l_mo <= n_mo;
            l_st <= n_st;
            l_so <= n_so;
            l_ht <= n_ht;
            l_ho <= n_ho;
            tick <= inc;
            wrap <= c6;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] live_vec, next_vec, disp;
    logic        hold;

    assign live_vec = {l_mt, l_mo, l_st, l_so, l_ht, l_ho};
    assign next_vec = {n_mt, n_mo, n_st, n_so, n_ht, n_ho};

    // The display register tracks the next live value so it stays aligned with tick;
    // a capture takes the pre-increment value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold <= 1'b0;
            disp <= '0;
        end else if (lap && !hold) begin
            hold <= 1'b1;
            disp <= live_vec;
        end else if (lap) begin
            hold <= 1'b0;
            disp <= next_vec;
        end else if (!hold) begin
            disp <= next_vec;
        end
    end

    assign {min_t, min_o, sec_t, sec_o, hun_t, hun_o} = disp;
    assign lap_active = hold;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign {min_t, min_o, sec_t, sec_o, hun_t, hun_o} = {l_mt, l_mo, l_st, l_so, l_ht, l_ho};
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench for stopwatch_time_counter at CLK_HZ=1000 (DIV=10, DIV_FAST=1),
// using a count-in-hundredths reference model.
module tb_stopwatch_time_counter;

    localparam int CLK_HZ   = 1000;
    localparam int DIV      = CLK_HZ / 100;
    localparam int DIV_FAST = CLK_HZ / 1000;
    localparam int TOTAL    = 60 * 60 * 100;

    logic       clk = 1'b0;
    logic       rst, clear, run, fast, lap;
    logic [3:0] min_t, min_o, sec_t, sec_o, hun_t, hun_o;
    logic       tick, wrap, lap_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time held as an integer number of hundredths.
    int m_pre, m_count, m_disp;
    bit m_lap_active, m_tick, m_wrap;

    stopwatch_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .clear(clear), .run(run), .fast(fast), .lap(lap),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .hun_t(hun_t), .hun_o(hun_o),
        .tick(tick), .wrap(wrap), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    wire [23:0] shown = {min_t, min_o, sec_t, sec_o, hun_t, hun_o};
    wire [26:0] obs   = {shown, tick, wrap, lap_active};

    function automatic void model_step(input bit r, input bit c, input bit ru, input bit f, input bit l);
        int lim;
        bit inc;
        inc = 1'b0;
        if (r) begin
            m_pre = 0; m_count = 0; m_disp = 0;
            m_lap_active = 0; m_tick = 0; m_wrap = 0;
        end else if (c) begin
            m_pre = 0; m_count = 0;
            m_lap_active = 0; m_tick = 0; m_wrap = 0;
        end else begin
            lim = f ? DIV_FAST : DIV;
            m_tick = 0;
            m_wrap = 0;
            if (ru) begin
                if (m_pre >= lim - 1) begin
                    m_pre = 0;
                    inc = 1'b1;
                end else begin
                    m_pre++;
                end
            end
`ifdef STOPWATCH_LAP_EN
            if (l) begin
                if (!m_lap_active) begin
                    m_disp = m_count;
                    m_lap_active = 1;
                end else begin
                    m_lap_active = 0;
                end
            end
`endif
            if (inc) begin
                m_count = (m_count + 1) % TOTAL;
                m_tick  = 1;
                m_wrap  = (m_count == 0);
            end
        end
    endfunction

    function automatic logic [23:0] to_bcd(input int hundredths);
        int mins, secs, hun;
        mins = hundredths / 6000;
        secs = (hundredths / 100) % 60;
        hun  = hundredths % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(hun / 10), 4'(hun % 10)};
    endfunction

    function automatic logic [26:0] expected_vec();
        return {to_bcd(m_lap_active ? m_disp : m_count), m_tick, m_wrap, m_lap_active};
    endfunction

    // Drive one cycle's inputs, advance the model on the edge, settle past the edge.
    task automatic cycle(input bit r, input bit c, input bit ru, input bit f, input bit l);
        rst = r; clear = c; run = ru; fast = f; lap = l;
        @(posedge clk);
        model_step(r, c, ru, f, l);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        n_tests++;
        if (obs !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 27'd0);
        end
        cycle(0, 0, 0, 0, 0);
        n_tests++;
        if (obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", obs, expected_vec());
        end
    endtask

    task automatic test_normal_rate();
        int ticks, bad;
        ticks = 0;
        bad = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (tick) ticks++;
            if (tick !== (i % 10 == 0) || obs !== expected_vec()) bad++;
        end
        n_tests++;
        if (ticks != 10) begin
            n_fail++;
            $display("FAIL normal_tick_count got=%0d exp=%0d", ticks, 10);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL normal_tick_positions bad_cycles=%0d exp=0", bad);
        end
        n_tests++;
        if (shown !== 24'h000010) begin
            n_fail++;
            $display("FAIL normal_display got=%h exp=%h", shown, 24'h000010);
        end
    endtask

    task automatic test_fast_pause();
        logic [23:0] held;
        int bad;
        bad = 0;
        cycle(1, 0, 0, 0, 0);
        repeat (25) cycle(0, 0, 1, 1, 0);
        n_tests++;
        if (shown !== 24'h000025) begin
            n_fail++;
            $display("FAIL fast_display got=%h exp=%h", shown, 24'h000025);
        end
        held = shown;
        repeat (50) begin
            cycle(0, 0, 0, 0, 0);
            if (shown !== 24'h000025 || tick !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL pause_hold bad_cycles=%0d last=%h exp=%h", bad, held, 24'h000025);
        end
        repeat (10) cycle(0, 0, 1, 0, 0);
        n_tests++;
        if (shown !== 24'h000026) begin
            n_fail++;
            $display("FAIL resume_display got=%h exp=%h", shown, 24'h000026);
        end
    endtask

    task automatic test_clear_mid_period();
        int first_tick;
        first_tick = -1;
        cycle(1, 0, 0, 0, 0);
        repeat (25) cycle(0, 0, 1, 0, 0);
        repeat (7) cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        n_tests++;
        if ({shown, tick, wrap} !== 26'd0) begin
            n_fail++;
            $display("FAIL clear_zero got=%h exp=%h", {shown, tick, wrap}, 26'd0);
        end
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (tick && first_tick < 0) first_tick = i;
        end
        n_tests++;
        if (first_tick != 10) begin
            n_fail++;
            $display("FAIL clear_first_tick got=%0d exp=%0d", first_tick, 10);
        end
    endtask

    task automatic test_lap();
        cycle(1, 0, 0, 0, 0);
        repeat (30) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        n_tests++;
        if ({shown, lap_active} !== {24'h000030, 1'b1}) begin
            n_fail++;
            $display("FAIL lap_capture got=%h/%b exp=%h/%b", shown, lap_active, 24'h000030, 1'b1);
        end
`endif
        repeat (20) cycle(0, 0, 1, 1, 0);
        n_tests++;
        if (obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL lap_during_hold got=%h exp=%h", obs, expected_vec());
        end
        cycle(0, 0, 0, 0, 1);
        n_tests++;
        if ({shown, lap_active} !== {24'h000050, 1'b0}) begin
            n_fail++;
            $display("FAIL lap_release got=%h/%b exp=%h/%b", shown, lap_active, 24'h000050, 1'b0);
        end
        // Lap on an increment edge captures the pre-increment value.
        cycle(0, 0, 1, 1, 1);
        n_tests++;
        if (obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL lap_on_increment got=%h exp=%h", obs, expected_vec());
        end
        cycle(0, 1, 1, 1, 1);
        n_tests++;
        if ({shown, lap_active} !== 25'd0) begin
            n_fail++;
            $display("FAIL lap_with_clear got=%h/%b exp=0/0", shown, lap_active);
        end
    endtask

    task automatic test_reset_mid_run();
        cycle(1, 0, 0, 0, 0);
        repeat (1234) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1);
        n_tests++;
        if (obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL reset_mid_pre got=%h exp=%h", obs, expected_vec());
        end
        cycle(1, 0, 1, 1, 0);
        n_tests++;
        if (obs !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run got=%h exp=%h", obs, 27'd0);
        end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < TOTAL - 1; i++) begin
            cycle(0, 0, 1, 1, 0);
            if (tick !== 1'b1 || wrap !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_preload_pulses bad_cycles=%0d exp=0", bad);
        end
        n_tests++;
        if (shown !== 24'h595999) begin
            n_fail++;
            $display("FAIL wrap_preload got=%h exp=%h", shown, 24'h595999);
        end
        cycle(0, 0, 1, 1, 0);
        n_tests++;
        if ({shown, tick, wrap} !== {24'h000000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_rollover got=%h exp=%h", {shown, tick, wrap}, {24'h000000, 2'b11});
        end
        cycle(0, 0, 0, 0, 0);
        n_tests++;
        if ({tick, wrap} !== 2'b00) begin
            n_fail++;
            $display("FAIL wrap_width got=%b exp=%b", {tick, wrap}, 2'b00);
        end
    endtask

    task automatic test_random();
        int bad;
        logic [26:0] first_got, first_exp;
        bit r, c, ru, f, l;
        bad = 0;
        first_got = '0;
        first_exp = '0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            c  = ($urandom_range(0, 59) == 0);
            ru = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 24) == 0);
            cycle(r, c, ru, f, l);
            if (obs !== expected_vec()) begin
                if (bad == 0) begin
                    first_got = obs;
                    first_exp = expected_vec();
                end
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL random_vs_model bad_cycles=%0d first got=%h exp=%h", bad, first_got, first_exp);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; run = 1'b0; fast = 1'b0; lap = 1'b0;
        m_pre = 0; m_count = 0; m_disp = 0;
        m_lap_active = 0; m_tick = 0; m_wrap = 0;
        test_reset();
        test_normal_rate();
        test_fast_pause();
        test_clear_mid_period();
        test_lap();
        test_reset_mid_run();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
